mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter that sits on the processor's data-memory bus beside `dmem`. It is the responder for the core's store/load traffic in its address window. Stores push bytes into an internal FIFO. A serial shifter drains the FIFO onto `txd` as 8N1 frames. Loads return status in the same cycle, matching `dmem`'s combinational read timing.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; minimum 2.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥ 2.
- `BASE_ADDR`, 32'h0000_8000: window base; bits [3:0] must be 0.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `mem_write`  in  1: store strobe from the core.
- `adr`  in  32: byte address from the core (`alu_result`).
- `write_data`  in  32: store data from the core.
- `read_data`  out  32: combinational load data; 0 when `adr` is outside the window.
- `txd`  out  1: serial output, idle high.
- `busy`  out  1: high while a frame is being shifted.

## Operation
- Address decode: selected when `adr[31:4] == BASE_ADDR[31:4]`. `adr[3:2]` selects the register. `adr[1:0]` is ignored.
- Offset 0x0, TXDATA:
  - Write pushes `write_data[7:0]` if the FIFO is not full.
  - Read returns 0.
- Offset 0x4, STATUS (read):
  - bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky).
  - bits[8+CW-1:8] FIFO count, CW = $clog2(FIFO_DEPTH)+1.
  - Write: bit3 = 1 clears overflow (W1C); other bits ignored.
- Offset 0x8, CTRL:
  - bit0 enable, read/write, reset value 1.
  - Reads return the register; other bits read 0.
- Offset 0xC: reserved; reads 0, writes ignored.
- A push while full is dropped and sets overflow.
  - "Full" is judged on the pre-edge state, so the push is dropped even if a pop happens in the same cycle.
  - The pop still occurs.
- FSM states:
  - IDLE: `txd`=1. If enable && !empty, pop the head into the shift register and go to START.
  - START: `txd`=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: `txd`=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. After bit 7, go to STOP.
  - STOP: `txd`=1 for CLKS_PER_BIT cycles. At its end, if enable && !empty, pop and go to START (no idle gap); otherwise go to IDLE.
- `busy` = (state != IDLE).
- Clearing enable mid-frame completes the current frame; no further pops occur.
- Bit counter is $clog2(CLKS_PER_BIT) wide and counts 0..CLKS_PER_BIT-1, then wraps.
- FIFO pointers are CW-1 bits and wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - `txd`=1, `busy`=0, state IDLE.
  - FIFO empty (count 0), overflow=0, enable=1, counters 0.
- `read_data` is purely combinational from `adr` and current state; no reset dependency.
- A store sampled at edge E makes the FIFO non-empty after E. In IDLE, the pop happens at edge E+1, and `txd` is 0 from E+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames have no extra cycles.
- STATUS reflects a push or pop in the cycle after the edge that performed it.
- Reset mid-frame: at the reset edge, the frame is abandoned, the FIFO is flushed, and `txd` returns to 1.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t`.
  - Register offset localparams `TXDATA_OFS`, `STATUS_OFS`, `CTRL_OFS`.
  - STATUS bit-position localparams.
- Sub-module `sync_fifo`:
  - Parameters WIDTH, DEPTH.
  - Ports `clk`, `reset`, `push`, `din`, `pop`, `dout`, `full`, `empty`, `count`.
  - Synchronous reset; first-word-fall-through `dout`.
- Top-level system ORs `read_data` with `dmem` output, and gates `dmem`'s `mem_write` off for this window.

## Test plan
- CLKS_PER_BIT=4, reset, store 0x55 to BASE+0 → `txd` low one cycle after the store edge, then 1,0,1,0,1,0,1,0 for 4 cycles each, stop high 4 cycles; `busy` high for exactly 40 cycles.
- CTRL=0, store 9 bytes 0x01..0x09 → STATUS reads count=8, full=1, overflow=1; store 0x8 to STATUS → overflow=0, count still 8.
- Then CTRL=1 → 8 frames back-to-back, 320 cycles of `busy`, bytes 0x01..0x08 in order; 0x09 never appears.
- Reset during bit 3 of a frame with 2 bytes queued → `txd`=1 after the edge; STATUS reads empty=1, count=0, busy=0; no further frames.
- Store 0xAA to BASE+0x10 and BASE+0xC; load BASE+0x14 → no push, `read_data`=0; store to BASE+3 (adr[1:0]=11) → pushes.
- Store to TXDATA in the same cycle STOP ends with FIFO holding 1 byte → queued byte starts START immediately; new byte follows with no gap.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam logic [1:0] TXDATA_OFS = 2'd0;
   localparam logic [1:0] STATUS_OFS = 2'd1;
   localparam logic [1:0] CTRL_OFS   = 2'd2;

   localparam int ST_FULL_BIT  = 0;
   localparam int ST_EMPTY_BIT = 1;
   localparam int ST_BUSY_BIT  = 2;
   localparam int ST_OVF_BIT   = 3;
   localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output; pushes while full
// and pops while empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
      end
   end

   // Storage holds data only, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores fill a TX FIFO, a serial
// shifter drains it onto txd, loads return status combinationally.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_8000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_write,
   input  logic [31:0] adr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        txd,
   output logic        busy
);

   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic          sel;
   logic [1:0]    ofs;
   logic          wr_txdata;
   logic          wr_status;
   logic          wr_ctrl;
   logic          enable;
   logic          overflow;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic          unused_bits;

   tx_state_t        state, state_nx;
   logic [CNT_W-1:0] clk_cnt, clk_cnt_nx;
   logic [2:0]       bit_idx, bit_idx_nx;
   logic [7:0]       shift, shift_nx;
   logic             bit_end;

   assign sel         = (adr[31:4] == BASE_ADDR[31:4]);
   assign ofs         = adr[3:2];
   assign wr_txdata   = mem_write && sel && (ofs == TXDATA_OFS);
   assign wr_status   = mem_write && sel && (ofs == STATUS_OFS);
   assign wr_ctrl     = mem_write && sel && (ofs == CTRL_OFS);
   assign unused_bits = ^{adr[1:0], write_data[31:8]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_txdata),
      .din   (write_data[7:0]),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Full is the pre-edge FIFO state, so a push racing a pop is still lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         enable   <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (wr_ctrl) enable <= write_data[0];
         if (wr_txdata && fifo_full)
            overflow <= 1'b1;
         else if (wr_status && write_data[ST_OVF_BIT])
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         clk_cnt <= '0;
         bit_idx <= '0;
      end else begin
         state   <= state_nx;
         clk_cnt <= clk_cnt_nx;
         bit_idx <= bit_idx_nx;
      end
   end

   always_ff @(posedge clk) begin
      shift <= shift_nx;
   end

   assign bit_end = (clk_cnt == CNT_LAST);

   always_comb begin
      state_nx   = state;
      clk_cnt_nx = clk_cnt;
      bit_idx_nx = bit_idx;
      shift_nx   = shift;
      fifo_pop   = 1'b0;
      if (state != IDLE) clk_cnt_nx = bit_end ? '0 : clk_cnt + 1'b1;
      case (state)
         IDLE: begin
            if (enable && !fifo_empty) begin
               fifo_pop   = 1'b1;
               shift_nx   = fifo_dout;
               clk_cnt_nx = '0;
               state_nx   = START;
            end
         end
         START: begin
            if (bit_end) begin
               bit_idx_nx = '0;
               state_nx   = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_nx = shift >> 1;
               if (bit_idx == 3'd7) state_nx = STOP;
               else                 bit_idx_nx = bit_idx + 1'b1;
            end
         end
         STOP: begin
            // Chain straight into the next frame when more data is waiting.
            if (bit_end) begin
               if (enable && !fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_nx = fifo_dout;
                  state_nx = START;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign txd  = (state == START) ? 1'b0 :
                 (state == DATA)  ? shift[0] : 1'b1;
   assign busy = (state != IDLE);

   always_comb begin
      read_data = '0;
      if (sel) begin
         case (ofs)
            STATUS_OFS: begin
               read_data[ST_FULL_BIT]          = fifo_full;
               read_data[ST_EMPTY_BIT]         = fifo_empty;
               read_data[ST_BUSY_BIT]          = busy;
               read_data[ST_OVF_BIT]           = overflow;
               read_data[ST_COUNT_LSB +: CW]   = fifo_count;
            end
            CTRL_OFS: read_data[0] = enable;
            default:  read_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with a frame-level reference model checked every cycle.
module tb_mmio_uart_tx;

   localparam int          CPB   = 4;
   localparam int          DEPTH = 8;
   localparam int          FRAME = 10 * CPB;
   localparam logic [31:0] BASE  = 32'h0000_8000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_write = 1'b0;
   logic [31:0] adr = BASE;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        txd;
   logic        busy;

   always #5 clk = ~clk;

   mmio_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .BASE_ADDR    (BASE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_write  (mem_write),
      .adr        (adr),
      .write_data (write_data),
      .read_data  (read_data),
      .txd        (txd),
      .busy       (busy)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: byte queue plus cycles remaining in the current frame.
   logic [7:0] mq[$];
   int         m_left = 0;
   logic [7:0] m_byte = '0;
   bit         m_ovf = 0;
   bit         m_en = 1;
   bit         m_pre_full;
   bit         m_can_pop;
   bit         go = 0;

   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
         m_left = 0;
         m_ovf  = 0;
         m_en   = 1;
      end else begin
         m_pre_full = (mq.size() == DEPTH);
         m_can_pop  = m_en && (mq.size() != 0);
         if (m_left <= 1) begin
            if (m_can_pop) begin
               m_byte = mq.pop_front();
               m_left = FRAME;
            end else begin
               m_left = 0;
            end
         end else begin
            m_left--;
         end
         if (mem_write && adr[31:4] == BASE[31:4]) begin
            case (adr[3:2])
               2'd0: if (m_pre_full) m_ovf = 1; else mq.push_back(write_data[7:0]);
               2'd1: if (write_data[3]) m_ovf = 0;
               2'd2: m_en = write_data[0];
               default: ;
            endcase
         end
      end
   end

   function automatic logic m_txd();
      int b;
      if (m_left == 0) return 1'b1;
      b = (FRAME - m_left) / CPB;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return m_byte[b-1];
   endfunction

   function automatic logic [31:0] m_rd(input logic [31:0] a);
      logic [31:0] r;
      r = '0;
      if (a[31:4] == BASE[31:4]) begin
         if (a[3:2] == 2'd1) begin
            r = (mq.size() << 8) | (32'(m_ovf) << 3) | (32'(m_left != 0) << 2)
              | (32'(mq.size() == 0) << 1) | 32'(mq.size() == DEPTH);
         end else if (a[3:2] == 2'd2) begin
            r = 32'(m_en);
         end
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (go) begin
         chk("model_txd", 32'(txd), 32'(m_txd()));
         chk("model_busy", 32'(busy), 32'(m_left != 0));
         chk("model_read_data", read_data, m_rd(adr));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      adr = a;
      write_data = d;
      mem_write = 1'b1;
      tick();
      mem_write = 1'b0;
   endtask

   task automatic rd_chk(input string n, input logic [31:0] a, input logic [31:0] e);
      adr = a;
      #1;
      chk(n, read_data, e);
   endtask

   task automatic wait_idle(input int maxc);
      int n;
      n = 0;
      while (busy && n < maxc) begin
         tick();
         n++;
      end
      chk("idle_within_bound", 32'(busy), 32'd0);
   endtask

   logic [9:0] pat;
   logic       samp_q[$];
   logic [7:0] v;
   int         n;
   int         bcnt;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      tick();
      tick();
      reset = 1'b0;
      go = 1;
      chk("reset_txd", 32'(txd), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      rd_chk("reset_status", BASE + 32'h4, 32'h0000_0002);
      rd_chk("reset_ctrl", BASE + 32'h8, 32'h0000_0001);

      // Single frame of 0x55
      pat = 10'b1010101010;
      store(BASE, 32'h55);
      chk("t1_txd_before_pop", 32'(txd), 32'd1);
      chk("t1_busy_before_pop", 32'(busy), 32'd0);
      tick();
      bcnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         chk("t1_frame_bit", 32'(txd), 32'(pat[i / CPB]));
         if (busy) bcnt++;
         tick();
      end
      chk("t1_busy_cycles", bcnt, 32'd40);
      chk("t1_busy_after", 32'(busy), 32'd0);
      chk("t1_txd_after", 32'(txd), 32'd1);

      // Fill with enable off, overflow, W1C
      store(BASE + 32'h8, 32'h0);
      for (int i = 1; i <= 9; i++) store(BASE, 32'(i));
      rd_chk("t2_status_full_ovf", BASE + 32'h4, 32'h0000_0809);
      store(BASE + 32'h4, 32'h8);
      rd_chk("t2_status_ovf_clr", BASE + 32'h4, 32'h0000_0801);

      // Drain 8 frames back-to-back
      store(BASE + 32'h8, 32'h1);
      n = 0;
      while (!busy && n < 10) begin
         tick();
         n++;
      end
      n = 0;
      while (busy && n < 400) begin
         samp_q.push_back(txd);
         n++;
         tick();
      end
      chk("t3_busy_cycles", n, 32'd320);
      for (int k = 0; k < 8; k++) begin
         v = '0;
         for (int b = 0; b < 8; b++) begin
            if (k * FRAME + (b + 1) * CPB + 2 < samp_q.size())
               v[b] = samp_q[k * FRAME + (b + 1) * CPB + 2];
         end
         chk("t3_byte", 32'(v), 32'(k + 1));
      end
      rd_chk("t3_status_drained", BASE + 32'h4, 32'h0000_0002);

      // Reset mid-frame with two bytes queued
      store(BASE, 32'h11);
      store(BASE, 32'h22);
      store(BASE, 32'h33);
      for (int i = 0; i < 16; i++) tick();
      chk("t4_busy_mid_frame", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t4_txd_after_reset", 32'(txd), 32'd1);
      chk("t4_busy_after_reset", 32'(busy), 32'd0);
      rd_chk("t4_status_after_reset", BASE + 32'h4, 32'h0000_0002);
      bcnt = 0;
      for (int i = 0; i < 60; i++) begin
         if (busy) bcnt++;
         tick();
      end
      chk("t4_no_frames", bcnt, 32'd0);

      // Address decode
      store(BASE + 32'h10, 32'hAA);
      store(BASE + 32'hC, 32'hAA);
      rd_chk("t5_status_no_push", BASE + 32'h4, 32'h0000_0002);
      rd_chk("t5_outside_read", BASE + 32'h14, 32'h0);
      rd_chk("t5_reserved_read", BASE + 32'hC, 32'h0);
      rd_chk("t5_txdata_read", BASE, 32'h0);
      store(BASE + 32'h3, 32'h3C);
      rd_chk("t5_low_bits_push", BASE + 32'h4, 32'h0000_0100);
      tick();
      wait_idle(60);

      // Store landing on the last STOP cycle
      store(BASE, 32'hC3);
      store(BASE, 32'h5A);
      bcnt = 0;
      for (int i = 0; i < 39; i++) begin
         if (busy) bcnt++;
         tick();
      end
      if (busy) bcnt++;
      store(BASE, 32'h96);
      chk("t6_next_start_immediate", 32'(txd), 32'd0);
      n = 0;
      while (busy && n < 200) begin
         bcnt++;
         n++;
         tick();
      end
      chk("t6_busy_gapless", bcnt, 32'd120);
      wait_idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
